// File: rtl/ps2_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder_if
//   Bundles the PS/2 line inputs and the scan-code register command outputs
//   of ps2_scan_decoder.
//   ps2_clk   : raw PS/2 clock line (asynchronous to clk)
//   ps2_data  : raw PS/2 data line (asynchronous to clk)
//   data_out  : last decoded scan byte, feeds the holding register data_in
//   tn        : register command, 00 clear / 01 load / 10 hold
//   frame_err : one-cycle pulse on framing, parity or timeout error
//   Modport slave is the decoder; modport master is the keyboard/register side.
// ---------------------------------------------------------------------------
interface ps2_scan_decoder_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] data_out;
   logic [1:0] tn;
   logic       frame_err;

   modport slave (
      input  ps2_clk,
      input  ps2_data,
      output data_out,
      output tn,
      output frame_err
   );

   modport master (
      output ps2_clk,
      output ps2_data,
      input  data_out,
      input  tn,
      input  frame_err
   );
endinterface

// File: rtl/ps2_scan_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scan_decoder
//   Deframes 11-bit PS/2 keyboard frames (start, 8 data LSB first, odd
//   parity, stop) and turns make/break sequences into byte + command pairs
//   for the downstream 8-bit scan-code holding register.
//   clk   : system clock, all logic on posedge
//   rst_n : synchronous active-low reset
//   bus   : ps2_scan_decoder_if.slave (ps2_clk/ps2_data in,
//           data_out/tn/frame_err out, all outputs registered)
//   TIMEOUT_CYCLES : clk cycles allowed between ps2_clk falling edges
//                    inside a frame before the frame is abandoned.
// ---------------------------------------------------------------------------
module ps2_scan_decoder #(
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ps2_scan_decoder_if.slave     bus
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] TN_CLEAR = 2'b00;
   localparam logic [1:0] TN_LOAD  = 2'b01;
   localparam logic [1:0] TN_HOLD  = 2'b10;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Synchronizers and edge detect; idle-high lines, so reset to 1
   logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
   logic ps2d_s1_q, ps2d_s2_q;
   logic fe;

   state_t           state_q, state_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             par_q, par_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             brk_q, brk_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       tn_q, tn_d;
   logic             err_q, err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ps2c_s1_q   <= 1'b1;
         ps2c_s2_q   <= 1'b1;
         ps2c_prev_q <= 1'b1;
         ps2d_s1_q   <= 1'b1;
         ps2d_s2_q   <= 1'b1;
      end else begin
         ps2c_s1_q   <= bus.ps2_clk;
         ps2c_s2_q   <= ps2c_s1_q;
         ps2c_prev_q <= ps2c_s2_q;
         ps2d_s1_q   <= bus.ps2_data;
         ps2d_s2_q   <= ps2d_s1_q;
      end
   end

   assign fe = ps2c_prev_q & ~ps2c_s2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         shreg_q   <= 8'h00;
         par_q     <= 1'b0;
         to_cnt_q  <= '0;
         brk_q     <= 1'b0;
         data_q    <= 8'h00;
         tn_q      <= TN_HOLD;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         to_cnt_q  <= to_cnt_d;
         brk_q     <= brk_d;
         data_q    <= data_d;
         tn_q      <= tn_d;
         err_q     <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      brk_d     = brk_q;
      data_d    = data_q;
      tn_d      = TN_HOLD;
      err_d     = 1'b0;
      to_cnt_d  = (state_q == IDLE) ? '0 : to_cnt_q + CNT_W'(1);

      case (state_q)
         IDLE: begin
            // A high bit on a falling edge is not a start bit; ignore it
            if (fe && !ps2d_s2_q) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
               to_cnt_d  = '0;
            end
         end
         DATA: begin
            if (fe) begin
               shreg_d   = {ps2d_s2_q, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               to_cnt_d  = '0;
               if (bit_cnt_q == 3'd7) state_d = PARITY;
            end
         end
         PARITY: begin
            if (fe) begin
               par_d    = ps2d_s2_q;
               to_cnt_d = '0;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (fe) begin
               state_d  = IDLE;
               to_cnt_d = '0;
               if ((^{shreg_q, par_q}) && ps2d_s2_q) begin
                  case (shreg_q)
                     8'hF0: brk_d = 1'b1;
                     8'hE0: ;  // extended prefix carries no key information
                     default: begin
                        data_d = shreg_q;
                        if (brk_q) begin
                           tn_d  = TN_CLEAR;
                           brk_d = 1'b0;
                        end else begin
                           tn_d  = TN_LOAD;
                        end
                     end
                  endcase
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A falling edge on the same cycle keeps the frame alive
      if (state_q != IDLE && !fe && to_cnt_q == TO_LAST) begin
         state_d   = IDLE;
         bit_cnt_d = 3'd0;
         to_cnt_d  = '0;
         err_d     = 1'b1;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.tn        = tn_q;
   assign bus.frame_err = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
module tb_ps2_scan_decoder;
   localparam int TO = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   // Event counters sampled on the falling clk edge
   int   n_load = 0, n_clr = 0, n_bad = 0, n_err = 0;
   logic [7:0] cmd_data = 8'h00;

   ps2_scan_decoder_if bus ();

   ps2_scan_decoder #(.TIMEOUT_CYCLES(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.tn == 2'b01) n_load <= n_load + 1;
      if (bus.tn == 2'b00) n_clr  <= n_clr + 1;
      if (bus.tn == 2'b11) n_bad  <= n_bad + 1;
      if (bus.frame_err)   n_err  <= n_err + 1;
      if (bus.tn != 2'b10) cmd_data <= bus.data_out;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic ps2_bit(input logic b);
      @(negedge clk); bus.ps2_data = b;
      repeat (4) @(negedge clk); bus.ps2_clk = 1'b0;
      repeat (8) @(negedge clk); bus.ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit((~^d) ^ par_flip);
      ps2_bit(stop);
      @(negedge clk); bus.ps2_data = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++;
      if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.data_out); end
      n_tests++;
      if (bus.tn !== 2'b10) begin n_fail++; $display("FAIL reset_tn: got %b expected 10", bus.tn); end
      n_tests++;
      if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus.frame_err); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_load();
      int l0, c0, e0;
      l0 = n_load; c0 = n_clr; e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 1 || n_clr - c0 !== 0) begin n_fail++; $display("FAIL load_1c_cmd: got load=%0d clr=%0d expected load=1 clr=0", n_load - l0, n_clr - c0); end
      n_tests++;
      if (cmd_data !== 8'h1C || bus.data_out !== 8'h1C) begin n_fail++; $display("FAIL load_1c_data: got cmd=%h out=%h expected 1c", cmd_data, bus.data_out); end
      n_tests++;
      if (n_err - e0 !== 0 || bus.tn !== 2'b10) begin n_fail++; $display("FAIL load_1c_idle: got err=%0d tn=%b expected 0 10", n_err - e0, bus.tn); end
   endtask

   task automatic test_break();
      int l0, c0;
      l0 = n_load; c0 = n_clr;
      send_frame(8'hF0, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 0 || n_clr - c0 !== 0 || bus.data_out !== 8'h1C) begin n_fail++; $display("FAIL break_f0: got load=%0d clr=%0d out=%h expected 0 0 1c", n_load - l0, n_clr - c0, bus.data_out); end
      l0 = n_load; c0 = n_clr;
      send_frame(8'h1C, 1'b0, 1'b1);
      n_tests++;
      if (n_clr - c0 !== 1 || n_load - l0 !== 0 || cmd_data !== 8'h1C) begin n_fail++; $display("FAIL break_1c: got clr=%0d load=%0d cmd=%h expected 1 0 1c", n_clr - c0, n_load - l0, cmd_data); end
      l0 = n_load; c0 = n_clr;
      send_frame(8'h32, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 1 || n_clr - c0 !== 0 || bus.data_out !== 8'h32) begin n_fail++; $display("FAIL break_cleared_32: got load=%0d clr=%0d out=%h expected 1 0 32", n_load - l0, n_clr - c0, bus.data_out); end
   endtask

   task automatic test_extended();
      int l0, c0;
      l0 = n_load; c0 = n_clr;
      send_frame(8'hE0, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 0 || n_clr - c0 !== 0 || bus.data_out !== 8'h32) begin n_fail++; $display("FAIL ext_e0: got load=%0d clr=%0d out=%h expected 0 0 32", n_load - l0, n_clr - c0, bus.data_out); end
      l0 = n_load; c0 = n_clr;
      send_frame(8'h75, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 1 || n_clr - c0 !== 0 || bus.data_out !== 8'h75) begin n_fail++; $display("FAIL ext_75: got load=%0d clr=%0d out=%h expected 1 0 75", n_load - l0, n_clr - c0, bus.data_out); end
   endtask

   task automatic test_frame_errors();
      int l0, c0, e0;
      l0 = n_load; c0 = n_clr; e0 = n_err;
      send_frame(8'h1C, 1'b1, 1'b1);
      n_tests++;
      if (n_err - e0 !== 1 || n_load - l0 !== 0 || n_clr - c0 !== 0 || bus.data_out !== 8'h75) begin n_fail++; $display("FAIL bad_parity: got err=%0d load=%0d clr=%0d out=%h expected 1 0 0 75", n_err - e0, n_load - l0, n_clr - c0, bus.data_out); end
      l0 = n_load; c0 = n_clr; e0 = n_err;
      send_frame(8'h1C, 1'b0, 1'b0);
      n_tests++;
      if (n_err - e0 !== 1 || n_load - l0 !== 0 || n_clr - c0 !== 0 || bus.data_out !== 8'h75) begin n_fail++; $display("FAIL bad_stop: got err=%0d load=%0d clr=%0d out=%h expected 1 0 0 75", n_err - e0, n_load - l0, n_clr - c0, bus.data_out); end
      // A bad frame between F0 and the key must leave the break flag set
      send_frame(8'hF0, 1'b0, 1'b1);
      send_frame(8'h55, 1'b1, 1'b1);
      l0 = n_load; c0 = n_clr;
      send_frame(8'h2B, 1'b0, 1'b1);
      n_tests++;
      if (n_clr - c0 !== 1 || n_load - l0 !== 0 || bus.data_out !== 8'h2B) begin n_fail++; $display("FAIL err_keeps_break: got clr=%0d load=%0d out=%h expected 1 0 2b", n_clr - c0, n_load - l0, bus.data_out); end
   endtask

   task automatic test_timeout();
      int e0, l0, c0, n;
      logic [7:0] d;
      bit   seen;
      d = 8'h5A;
      e0 = n_err;
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(d[i]);
      @(negedge clk); bus.ps2_data = d[3];
      repeat (4) @(negedge clk); bus.ps2_clk = 1'b0;
      n = 0; seen = 1'b0;
      while (!seen && n < TO + 20) begin
         @(posedge clk); #1;
         n++;
         if (n == 8) bus.ps2_clk = 1'b1;
         if (bus.frame_err) seen = 1'b1;
      end
      n_tests++;
      if (!seen || n !== TO + 3) begin n_fail++; $display("FAIL timeout_latency: got seen=%0d cycles=%0d expected 1 %0d", seen, n, TO + 3); end
      bus.ps2_data = 1'b1;
      repeat (6) @(negedge clk);
      n_tests++;
      if (n_err - e0 !== 1) begin n_fail++; $display("FAIL timeout_pulse: got %0d err cycles expected 1", n_err - e0); end
      l0 = n_load; c0 = n_clr; e0 = n_err;
      send_frame(8'h32, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 1 || n_clr - c0 !== 0 || n_err - e0 !== 0 || bus.data_out !== 8'h32) begin n_fail++; $display("FAIL timeout_recover: got load=%0d clr=%0d err=%0d out=%h expected 1 0 0 32", n_load - l0, n_clr - c0, n_err - e0, bus.data_out); end
   endtask

   task automatic test_reset_midframe();
      int e0, l0, c0;
      send_frame(8'hF0, 1'b0, 1'b1);
      e0 = n_err;
      ps2_bit(1'b0);
      ps2_bit(1'b1);
      ps2_bit(1'b0);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      n_tests++;
      if (bus.data_out !== 8'h00 || bus.tn !== 2'b10 || bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: got out=%h tn=%b err=%b expected 00 10 0", bus.data_out, bus.tn, bus.frame_err); end
      bus.ps2_data = 1'b1;
      repeat (TO + 20) @(negedge clk);
      n_tests++;
      if (n_err - e0 !== 0) begin n_fail++; $display("FAIL midreset_no_err: got %0d err cycles expected 0", n_err - e0); end
      l0 = n_load; c0 = n_clr;
      send_frame(8'h2B, 1'b0, 1'b1);
      n_tests++;
      if (n_load - l0 !== 1 || n_clr - c0 !== 0 || bus.data_out !== 8'h2B) begin n_fail++; $display("FAIL midreset_2b: got load=%0d clr=%0d out=%h expected 1 0 2b", n_load - l0, n_clr - c0, bus.data_out); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_break();
      test_extended();
      test_frame_errors();
      test_timeout();
      test_reset_midframe();
      n_tests++;
      if (n_bad !== 0) begin n_fail++; $display("FAIL tn_illegal: got %0d cycles of tn=11 expected 0", n_bad); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_scan_decoder.md
# ps2_scan_decoder

Receives the raw PS/2 keyboard serial stream (ps2_clk/ps2_data), deframes 11-bit frames and decodes make/break sequences into byte-plus-command pairs. It sits directly upstream of the 8-bit scan-code holding register. It drives that register's data_in and its 2-bit tn command input (clear/load/hold).

## Interface
- TIMEOUT_CYCLES, default 5000: clk cycles allowed between ps2_clk falling edges inside a frame before the frame is aborted.

- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  synchronous, active-low reset.
- ps2_clk  input  1  asynchronous PS/2 clock line from the keyboard.
- ps2_data  input  1  asynchronous PS/2 data line from the keyboard.
- data_out  output  8  last decoded scan byte; feeds the register's data_in.
- tn  output  2  command to the register: 2'b00 clear, 2'b01 load, 2'b10 hold.
- frame_err  output  1  one-cycle pulse on a framing, parity or timeout error.

## Operation
- Input conditioning:
  - Both PS/2 lines pass through 2-flop synchronizers.
  - A falling edge (fe) is registered previous sync ps2_clk = 1 and current = 0.
  - All bit sampling uses the synchronized ps2_data on the fe cycle.
- Frame format: start (0), 8 data bits LSB first, odd parity, stop (1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data = 0, go to DATA and clear bit_cnt. On fe with data = 1, stay in IDLE with no error.
  - DATA: on fe, shift data into shreg[7] (right shift) and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on fe, latch the parity bit and go to STOP.
  - STOP: on fe, evaluate the frame and return to IDLE.
- Frame is valid when XOR of the 8 data bits and the parity bit = 1, and stop = 1.
- Invalid frame: frame_err = 1 for one cycle. No tn command is issued and break_pending is unchanged.
- Valid byte handling (break_pending is an internal flag):
  - 0xF0: set break_pending. No command.
  - 0xE0: swallowed. No command, flags unchanged.
  - Any other byte with break_pending = 1: data_out <= byte, tn = clear for one cycle, then clear break_pending.
  - Any other byte with break_pending = 0: data_out <= byte, tn = load for one cycle.
- tn is 2'b10 (hold) at all other times. 2'b11 is never driven.
- data_out changes only on a load or clear command and otherwise holds its value. The register downstream latches two edges after tn = load, so data_out must stay stable for that long.
- Timeout:
  - A counter runs while the FSM is not IDLE and resets on every fe.
  - When the counter reaches TIMEOUT_CYCLES-1: return to IDLE, pulse frame_err and clear bit_cnt.
  - break_pending is unchanged by a timeout.

## Timing
- Reset (rst_n = 0 at a posedge) gives:
  - FSM = IDLE, bit_cnt = 0, timeout counter = 0, break_pending = 0.
  - data_out = 8'h00, tn = 2'b10, frame_err = 0.
  - Synchronizers and the edge-detect flop are set to 1.
- A reset mid-frame discards the partial frame with no frame_err.
- Latency from a ps2_clk pin falling edge to fe is 3 clk edges.
- tn, data_out and frame_err are registered. They update on the same posedge that samples the stop bit and are visible the following cycle.
- Every tn command lasts exactly one clk cycle. Back-to-back commands are impossible because frames take more than 10 fe.
- A fe and a timeout on the same cycle: the fe wins and the counter resets.
- The design requires the clk frequency to be at least 8x the PS/2 clock rate (10–16.7 kHz).

## Test plan
- Valid frame 0x1C (parity 0): data_out = 0x1C and tn = 01 for exactly one cycle, then tn = 10. frame_err stays 0.
- Sequence F0 then 1C: no command on F0. On 1C, tn = 00 for one cycle and data_out = 0x1C. A following 0x32 gives tn = 01, proving break_pending was cleared.
- Sequence E0 then 75: no command on E0. On 75, tn = 01 with data_out = 0x75.
- Frame 0x1C with parity bit 1: frame_err pulses one cycle, tn stays 10, data_out unchanged. Repeat with stop bit = 0 for the same result.
- Stop ps2_clk after 4 data bits: frame_err pulses TIMEOUT_CYCLES cycles after the last fe. A following valid frame 0x32 decodes correctly.
- Assert rst_n = 0 for one cycle mid-frame: all outputs return to reset values and frame_err = 0. The next full frame 0x2B gives tn = 01 and data_out = 0x2B.
